avalon_mem_responder: RTL and testbench

AVALON_MEM_RESPONDER -- requirements
Module: avalon_mem_responder

---
 rtl/avalon_mem_responder_if.sv | 33 +++
 rtl/avalon_mem_responder.sv | 118 +++++++++++
 tb/tb_avalon_mem_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mem_responder_if.sv
// rtl/avalon_mem_responder_if.sv - Avalon-MM style memory port bundle
// Purpose: groups the command and read-return signals of the 64-bit memory
// responder so that master and slave sides connect through one port.
// Signals:
//   avs_address[31:0]     byte address, word index = [31:3]
//   avs_byteenable[7:0]   write lane enables
//   avs_read / avs_write  command strobes, held until accepted
//   avs_writedata[63:0]   write data
//   avs_waitrequest       command not accepted this cycle
//   avs_readdata[63:0]    read return data
//   avs_readdatavalid     one-cycle read return strobe
//   avs_response[1:0]     00 OKAY, 10 SLAVEERROR, 11 DECODEERROR
interface avalon_mem_responder_if;
    logic [31:0] avs_address;
    logic [7:0]  avs_byteenable;
    logic        avs_read;
    logic        avs_write;
    logic [63:0] avs_writedata;
    logic        avs_waitrequest;
    logic [63:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [1:0]  avs_response;

    modport master (
        output avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid, avs_response
    );

    modport slave (
        input  avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
        output avs_waitrequest, avs_readdata, avs_readdatavalid, avs_response
    );
endinterface

// File: rtl/avalon_mem_responder.sv
// rtl/avalon_mem_responder.sv - 64-bit Avalon-MM memory responder with fixed read latency
// Purpose: byte-lane writable memory of DEPTH_WORDS 64-bit words. Reads are
// sampled at acceptance and returned exactly READ_LATENCY cycles later through
// a fixed shift register; at most MAX_PENDING reads may be in flight.
// Ports:
//   clk_i    clock, all state on rising edge
//   rst_i    asynchronous active-high reset (memory contents are kept)
//   stall_i  test hook, forces avs_waitrequest high
//   bus      avalon_mem_responder_if.slave (command in, read return out)
module avalon_mem_responder #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    stall_i,
    avalon_mem_responder_if.slave   bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PENDING);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [63:0]   mem [DEPTH_WORDS];

    logic [28:0]   word_idx;
    logic [AW-1:0] mem_idx;
    logic          in_range;
    logic          read_acc;
    logic          write_acc;
    logic [CW-1:0] pending_cnt;
    logic [63:0]   ret_data;
    logic [1:0]    ret_resp;
    logic          unused_addr_bits;

    logic          pipe_valid [READ_LATENCY];
    logic [63:0]   pipe_data  [READ_LATENCY];
    logic [1:0]    pipe_resp  [READ_LATENCY];

    assign word_idx         = bus.avs_address[31:3];
    assign mem_idx          = word_idx[AW-1:0];
    assign in_range         = {3'b000, word_idx} < 32'(DEPTH_WORDS);
    assign unused_addr_bits = ^bus.avs_address[2:0];

    // Deliberately independent of avs_read/avs_write so the master never sees
    // a combinational loop through the handshake.
    assign bus.avs_waitrequest = rst_i | stall_i | (pending_cnt == PEND_MAX);

    // Read+write together counts as a single (erroring) read.
    assign read_acc  = bus.avs_read & ~bus.avs_waitrequest;
    assign write_acc = bus.avs_write & ~bus.avs_read & ~bus.avs_waitrequest & in_range;

    always_comb begin
        ret_data = '0;
        ret_resp = RESP_OKAY;
        if (bus.avs_write) begin
            ret_resp = RESP_SLVERR;
        end else if (!in_range) begin
            ret_resp = RESP_DECERR;
        end else begin
            ret_data = mem[mem_idx];
        end
    end

    // Memory is not reset so contents survive an rst_i pulse.
    always_ff @(posedge clk_i) begin
        if (write_acc) begin
            for (int k = 0; k < 8; k++) begin
                if (bus.avs_byteenable[k]) begin
                    mem[mem_idx][8*k +: 8] <= bus.avs_writedata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_data[i]  <= '0;
                pipe_resp[i]  <= RESP_OKAY;
            end
        end else begin
            pipe_valid[0] <= read_acc;
            pipe_data[0]  <= read_acc ? ret_data : 64'd0;
            pipe_resp[0]  <= read_acc ? ret_resp : RESP_OKAY;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
                pipe_resp[i]  <= pipe_resp[i-1];
            end
        end
    end

    // Acceptance is blocked at PEND_MAX and a return implies a prior
    // acceptance, so the counter stays within 0..MAX_PENDING.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_cnt <= '0;
        end else begin
            case ({read_acc, bus.avs_readdatavalid})
                2'b10:   pending_cnt <= pending_cnt + 1'b1;
                2'b01:   pending_cnt <= pending_cnt - 1'b1;
                default: pending_cnt <= pending_cnt;
            endcase
        end
    end

    assign bus.avs_readdatavalid = pipe_valid[READ_LATENCY-1];
    assign bus.avs_readdata      = pipe_valid[READ_LATENCY-1] ? pipe_data[READ_LATENCY-1] : 64'd0;
    assign bus.avs_response      = pipe_valid[READ_LATENCY-1] ? pipe_resp[READ_LATENCY-1] : RESP_OKAY;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// tb/tb_avalon_mem_responder.sv - directed self-checking bench for avalon_mem_responder
module tb_avalon_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic stall0 = 1'b0;
    logic stall1 = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    avalon_mem_responder_if bus0 ();
    avalon_mem_responder_if bus1 ();

    avalon_mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT), .MAX_PENDING(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall0),
        .bus     (bus0)
    );

    avalon_mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT), .MAX_PENDING(1)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall1),
        .bus     (bus1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr0(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] be);
        bus0.avs_address    = addr;
        bus0.avs_writedata  = data;
        bus0.avs_byteenable = be;
        bus0.avs_write      = 1'b1;
        #1;
        chk("wr_ready", 64'(bus0.avs_waitrequest), 64'd0);
        step();
        bus0.avs_write = 1'b0;
    endtask

    task automatic rd0(input string tag, input logic [31:0] addr, input logic [63:0] exp_d,
                       input logic [1:0] exp_r);
        bus0.avs_address = addr;
        bus0.avs_read    = 1'b1;
        #1;
        chk({tag, "_ready"}, 64'(bus0.avs_waitrequest), 64'd0);
        step();
        bus0.avs_read = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            chk({tag, "_early_rdv"}, 64'(bus0.avs_readdatavalid), 64'd0);
            chk({tag, "_idle_data"}, bus0.avs_readdata, 64'd0);
            step();
        end
        chk({tag, "_rdv"}, 64'(bus0.avs_readdatavalid), 64'd1);
        chk({tag, "_data"}, bus0.avs_readdata, exp_d);
        chk({tag, "_resp"}, 64'(bus0.avs_response), 64'(exp_r));
    endtask

    initial begin
        int acc;
        int ret;

        bus0.avs_address = '0; bus0.avs_byteenable = '0; bus0.avs_read = 1'b0;
        bus0.avs_write = 1'b0; bus0.avs_writedata = '0;
        bus1.avs_address = '0; bus1.avs_byteenable = '0; bus1.avs_read = 1'b0;
        bus1.avs_write = 1'b0; bus1.avs_writedata = '0;

        // Reset state
        step();
        step();
        chk("rst_waitreq", 64'(bus0.avs_waitrequest), 64'd1);
        chk("rst_rdv", 64'(bus0.avs_readdatavalid), 64'd0);
        chk("rst_data", bus0.avs_readdata, 64'd0);
        chk("rst_resp", 64'(bus0.avs_response), 64'd0);
        chk("rst_waitreq1", 64'(bus1.avs_waitrequest), 64'd1);
        rst = 1'b0;
        #1;
        chk("first_cycle_ready", 64'(bus0.avs_waitrequest), 64'd0);

        // Preload and basic write/read
        wr0(32'h0, 64'hA5A5_0000_5A5A_FFFF, 8'hFF);
        wr0(32'h18, 64'h0, 8'hFF);
        wr0(32'h10, 64'h1122_3344_5566_7788, 8'hFF);
        rd0("wr_then_rd", 32'h10, 64'h1122_3344_5566_7788, 2'b00);

        // Partial byte enables
        wr0(32'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        rd0("be_0f", 32'h18, 64'h0000_0000_FFFF_FFFF, 2'b00);

        // byteenable 0 leaves word untouched
        wr0(32'h10, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
        rd0("be_00", 32'h10, 64'h1122_3344_5566_7788, 2'b00);

        // Low address bits ignored
        rd0("low_bits", 32'h17, 64'h1122_3344_5566_7788, 2'b00);

        // Out of range: decode error, writes discarded (no aliasing onto word 0)
        rd0("oor_rd", DEPTH * 8, 64'd0, 2'b11);
        wr0(DEPTH * 8, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        rd0("oor_no_alias", 32'h0, 64'hA5A5_0000_5A5A_FFFF, 2'b00);

        // Read + write together: slave error, no update
        bus0.avs_address   = 32'h0;
        bus0.avs_writedata = 64'hFFFF_FFFF_FFFF_FFFF;
        bus0.avs_byteenable = 8'hFF;
        bus0.avs_read  = 1'b1;
        bus0.avs_write = 1'b1;
        #1;
        chk("rw_ready", 64'(bus0.avs_waitrequest), 64'd0);
        step();
        bus0.avs_read  = 1'b0;
        bus0.avs_write = 1'b0;
        chk("rw_early_rdv", 64'(bus0.avs_readdatavalid), 64'd0);
        step();
        chk("rw_rdv", 64'(bus0.avs_readdatavalid), 64'd1);
        chk("rw_data", bus0.avs_readdata, 64'd0);
        chk("rw_resp", 64'(bus0.avs_response), 64'd2);
        rd0("rw_unchanged", 32'h0, 64'hA5A5_0000_5A5A_FFFF, 2'b00);

        // Back-to-back reads, reset after the second return
        bus0.avs_address = 32'h0;
        bus0.avs_read    = 1'b1;
        #1;
        chk("b2b_ready1", 64'(bus0.avs_waitrequest), 64'd0);
        step();
        bus0.avs_address = 32'h10;
        #1;
        chk("b2b_ready2", 64'(bus0.avs_waitrequest), 64'd0);
        chk("b2b_rdv_none", 64'(bus0.avs_readdatavalid), 64'd0);
        step();
        chk("b2b_ret1_rdv", 64'(bus0.avs_readdatavalid), 64'd1);
        chk("b2b_ret1_data", bus0.avs_readdata, 64'hA5A5_0000_5A5A_FFFF);
        bus0.avs_address = 32'h18;
        #1;
        chk("b2b_ready3", 64'(bus0.avs_waitrequest), 64'd0);
        step();
        chk("b2b_ret2_rdv", 64'(bus0.avs_readdatavalid), 64'd1);
        chk("b2b_ret2_data", bus0.avs_readdata, 64'h1122_3344_5566_7788);
        bus0.avs_address = 32'h0;
        rst = 1'b1;
        #1;
        chk("midrst_rdv", 64'(bus0.avs_readdatavalid), 64'd0);
        chk("midrst_waitreq", 64'(bus0.avs_waitrequest), 64'd1);
        step();
        bus0.avs_read = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("postrst_no_rdv", 64'(bus0.avs_readdatavalid), 64'd0);
        end
        rd0("postrst_mem", 32'h10, 64'h1122_3344_5566_7788, 2'b00);
        rd0("postrst_mem0", 32'h0, 64'hA5A5_0000_5A5A_FFFF, 2'b00);

        // Stall hook holds off a pending read for 3 cycles
        stall0 = 1'b1;
        bus0.avs_address = 32'h18;
        bus0.avs_read    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_waitreq", 64'(bus0.avs_waitrequest), 64'd1);
            step();
            chk("stall_no_rdv", 64'(bus0.avs_readdatavalid), 64'd0);
        end
        stall0 = 1'b0;
        #1;
        chk("unstall_ready", 64'(bus0.avs_waitrequest), 64'd0);
        step();
        bus0.avs_read = 1'b0;
        chk("unstall_early", 64'(bus0.avs_readdatavalid), 64'd0);
        step();
        chk("unstall_rdv", 64'(bus0.avs_readdatavalid), 64'd1);
        chk("unstall_data", bus0.avs_readdata, 64'h0000_0000_FFFF_FFFF);
        step();
        chk("unstall_once_a", 64'(bus0.avs_readdatavalid), 64'd0);
        step();
        chk("unstall_once_b", 64'(bus0.avs_readdatavalid), 64'd0);

        // MAX_PENDING=1: continuously held read, one outstanding at a time
        acc = 0;
        ret = 0;
        bus1.avs_address = 32'h10;
        bus1.avs_read    = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            if (bus1.avs_readdatavalid) ret++;
            chk("mp1_rdv", 64'(bus1.avs_readdatavalid), 64'((i % 3) == 2));
            chk("mp1_waitreq", 64'(bus1.avs_waitrequest), 64'((i % 3) != 0));
            chk("mp1_outstanding_le1", 64'((acc - ret) <= 1), 64'd1);
            if (!bus1.avs_waitrequest) acc++;
            step();
        end
        bus1.avs_read = 1'b0;
        chk("mp1_accepts", 64'(acc), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
